// File: rtl/phy_tx_lane_sched.sv
`default_nettype none
// ============================================================================
//  Module   : phy_tx_lane_sched
//  Purpose  : Round-robin byte scheduler that merges four byte requesters into
//             one registered byte stream (data/valid/K flag) for the PHY TX
//             serializer front end. Optional periodic SKP ordered-set
//             insertion (COM, SKP, SKP, SKP) is built when the macro
//             PHY_TX_SKP_INSERT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module phy_tx_lane_sched #(
  parameter int unsigned SKP_INTERVAL = 16,
  parameter logic [7:0]  COM_SYM      = 8'hBC,
  parameter logic [7:0]  SKP_SYM      = 8'h1C
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] In0,
  input  logic [7:0] In1,
  input  logic [7:0] In2,
  input  logic [7:0] In3,
  input  logic       valid0,
  input  logic       valid1,
  input  logic       valid2,
  input  logic       valid3,
  output logic       ready0,
  output logic       ready1,
  output logic       ready2,
  output logic       ready3,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       k_out,
  output logic [1:0] grant_id
);

  logic [3:0] w_valid;
  logic [3:0] w_ready;
  logic [1:0] w_idx;
  logic [1:0] w_gnt;
  logic       w_xfer;
  logic [7:0] w_din;
  logic       w_in_arb;
  logic [7:0] w_sym;

  logic [1:0] r_ptr;
  logic [7:0] r_data;
  logic       r_valid;
  logic [1:0] r_gid;

  assign w_valid = {valid3, valid2, valid1, valid0};

`ifdef PHY_TX_SKP_INSERT_EN
  typedef enum logic [2:0] {
    ST_ARB     = 3'd0,
    ST_SKP_COM = 3'd1,
    ST_SKP_1   = 3'd2,
    ST_SKP_2   = 3'd3,
    ST_SKP_3   = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_skp_cnt;
  logic [7:0] w_skp_cnt_nxt;
  logic       r_k;

  // State and SKP interval counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_ARB;
      r_skp_cnt <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_skp_cnt <= w_skp_cnt_nxt;
    end
  end

  // Next-state logic: count ARB cycles, then walk the four-symbol ordered set
  always_comb begin
    w_state_nxt   = r_state;
    w_skp_cnt_nxt = r_skp_cnt;
    w_in_arb      = 1'b0;
    w_sym         = SKP_SYM;
    case (r_state)
      ST_ARB: begin
        w_in_arb = 1'b1;
        if (r_skp_cnt == 8'(SKP_INTERVAL - 1)) begin
          w_skp_cnt_nxt = 8'h00;
          w_state_nxt   = ST_SKP_COM;
        end else begin
          w_skp_cnt_nxt = r_skp_cnt + 8'd1;
        end
      end
      ST_SKP_COM: begin
        w_sym       = COM_SYM;
        w_state_nxt = ST_SKP_1;
      end
      ST_SKP_1: w_state_nxt = ST_SKP_2;
      ST_SKP_2: w_state_nxt = ST_SKP_3;
      ST_SKP_3: w_state_nxt = ST_ARB;
      default:  w_state_nxt = ST_ARB;
    endcase
  end

  // K flag is set exactly for the cycles that carry an ordered-set symbol
  always_ff @(posedge clk) begin
    if (reset) begin
      r_k <= 1'b0;
    end else begin
      r_k <= ~w_in_arb;
    end
  end

  assign k_out = r_k;
`else
  logic w_unused_cfg;

  assign w_in_arb     = 1'b1;
  assign w_sym        = 8'h00;
  assign k_out        = 1'b0;
  assign w_unused_cfg = ^{8'(SKP_INTERVAL), COM_SYM, SKP_SYM};
`endif

  // Priority search starting at the pointer; the last hit written (k=0) is the
  // first lane in round-robin order, so it wins
  always_comb begin
    w_idx  = r_ptr;
    w_gnt  = r_ptr;
    w_xfer = 1'b0;
    if (!reset && w_in_arb) begin
      for (int k = 3; k >= 0; k--) begin
        w_idx = r_ptr + 2'(k);
        if (w_valid[w_idx]) begin
          w_gnt  = w_idx;
          w_xfer = 1'b1;
        end
      end
    end
    w_ready = w_xfer ? (4'b0001 << w_gnt) : 4'b0000;
  end

  // Byte select for the granted lane
  always_comb begin
    case (w_gnt)
      2'd0:    w_din = In0;
      2'd1:    w_din = In1;
      2'd2:    w_din = In2;
      default: w_din = In3;
    endcase
  end

  // Output register and round-robin pointer update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= 2'd0;
      r_data  <= 8'h00;
      r_valid <= 1'b0;
      r_gid   <= 2'd0;
    end else if (w_in_arb) begin
      if (w_xfer) begin
        r_data  <= w_din;
        r_valid <= 1'b1;
        r_gid   <= w_gnt;
        r_ptr   <= w_gnt + 2'd1;
      end else begin
        r_data  <= 8'h00;
        r_valid <= 1'b0;
      end
    end else begin
      r_data  <= w_sym;
      r_valid <= 1'b1;
    end
  end

  assign {ready3, ready2, ready1, ready0} = w_ready;
  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign grant_id  = r_gid;

endmodule
`default_nettype wire

// File: tb/tb_phy_tx_lane_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_phy_tx_lane_sched
//  Purpose  : Self-checking bench for phy_tx_lane_sched: directed vectors with
//             literal expectations plus a per-cycle comparison against a
//             behavioural model (PHY_TX_SKP_INSERT_EN aware).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_phy_tx_lane_sched;

  localparam int         SKP_IV = 16;
  localparam logic [7:0] COM    = 8'hBC;
  localparam logic [7:0] SKP    = 8'h1C;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] In0 = 8'h00, In1 = 8'h00, In2 = 8'h00, In3 = 8'h00;
  logic       valid0 = 1'b0, valid1 = 1'b0, valid2 = 1'b0, valid3 = 1'b0;
  logic       ready0, ready1, ready2, ready3;
  logic [7:0] data_out;
  logic       valid_out, k_out;
  logic [1:0] grant_id;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  phy_tx_lane_sched #(
    .SKP_INTERVAL(SKP_IV),
    .COM_SYM     (COM),
    .SKP_SYM     (SKP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .In0      (In0),
    .In1      (In1),
    .In2      (In2),
    .In3      (In3),
    .valid0   (valid0),
    .valid1   (valid1),
    .valid2   (valid2),
    .valid3   (valid3),
    .ready0   (ready0),
    .ready1   (ready1),
    .ready2   (ready2),
    .ready3   (ready3),
    .data_out (data_out),
    .valid_out(valid_out),
    .k_out    (k_out),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int         m_ptr;
  logic [7:0] m_data;
  logic       m_valid, m_k;
  int         m_gid;
  int         m_arb_cnt;   // ARB cycles since reset / last ordered set
  int         m_skp_left;  // ordered-set cycles still to emit (0 = arbitrating)
  int         m_g;

  function automatic int pick(input logic [3:0] v, input int p);
    for (int j = 0; j < 4; j++)
      if (v[(p + j) % 4]) return (p + j) % 4;
    return -1;
  endfunction

  function automatic logic [7:0] lane_byte(input int g);
    case (g)
      0: return In0;
      1: return In1;
      2: return In2;
      default: return In3;
    endcase
  endfunction

  function automatic logic [3:0] exp_ready();
    int g;
    if (reset || m_skp_left != 0) return 4'b0000;
    g = pick({valid3, valid2, valid1, valid0}, m_ptr);
    if (g < 0) return 4'b0000;
    return 4'(1 << g);
  endfunction

  // Model update on every rising edge
  always @(posedge clk) begin
    m_g = pick({valid3, valid2, valid1, valid0}, m_ptr);
    if (reset) begin
      m_ptr <= 0; m_data <= 8'h00; m_valid <= 1'b0; m_k <= 1'b0; m_gid <= 0;
      m_arb_cnt <= 0; m_skp_left <= 0;
    end else if (m_skp_left != 0) begin
      m_data     <= (m_skp_left == 4) ? COM : SKP;
      m_valid    <= 1'b1;
      m_k        <= 1'b1;
      m_skp_left <= m_skp_left - 1;
    end else begin
      if (m_g >= 0) begin
        m_data <= lane_byte(m_g); m_valid <= 1'b1; m_gid <= m_g;
        m_ptr  <= (m_g + 1) % 4;
      end else begin
        m_data <= 8'h00; m_valid <= 1'b0;
      end
      m_k <= 1'b0;
`ifdef PHY_TX_SKP_INSERT_EN
      if (m_arb_cnt == SKP_IV - 1) begin
        m_arb_cnt  <= 0;
        m_skp_left <= 4;
      end else begin
        m_arb_cnt <= m_arb_cnt + 1;
      end
`endif
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("m_ready", {4'h0, ready3, ready2, ready1, ready0}, {4'h0, exp_ready()});
      check("m_data", data_out, m_data);
      check("m_valid", {7'h0, valid_out}, {7'h0, m_valid});
      check("m_k", {7'h0, k_out}, {7'h0, m_k});
      check("m_gid", {6'h0, grant_id}, 8'(m_gid));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] v, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    {valid3, valid2, valid1, valid0} = v;
    In0 = b0; In1 = b1; In2 = b2; In3 = b3;
  endtask

  function automatic logic [7:0] rdy();
    return {4'h0, ready3, ready2, ready1, ready0};
  endfunction

  task automatic check_out(input string name, input logic [7:0] d, input logic v,
                           input logic k, input logic [1:0] gid);
    check({name, "_data"}, data_out, d);
    check({name, "_valid"}, {7'h0, valid_out}, {7'h0, v});
    check({name, "_k"}, {7'h0, k_out}, {7'h0, k});
    check({name, "_gid"}, {6'h0, grant_id}, {6'h0, gid});
  endtask

  logic [3:0] pats [12] = '{4'b0000, 4'b1111, 4'b0101, 4'b1010, 4'b0001, 4'b1000,
                            4'b1100, 4'b0011, 4'b0110, 4'b1001, 4'b0111, 4'b1110};

  initial begin
    // Reset values: three reset cycles with every lane valid
    reset = 1'b1;
    drive(4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_en = 1'b1;
      check("rst_ready", rdy(), 8'h00);
      check_out("rst", 8'h00, 1'b0, 1'b0, 2'd0);
    end

    // Round-robin with all four lanes valid
    reset = 1'b0;
    #1;
    check("rr_ready0", rdy(), 8'h01);
    for (int i = 0; i < 5; i++) begin
      step();
      check_out("rr", 8'hA0 + 8'(i % 4), 1'b1, 1'b0, 2'(i % 4));
    end

    // Single lane, then lanes 1 and 3 together after lane 2
    reset = 1'b1; step(); reset = 1'b0;
    drive(4'b0100, 8'h00, 8'h00, 8'h10, 8'h00);
    #1; check("sl_ready", rdy(), 8'h04);
    step(); check_out("sl0", 8'h10, 1'b1, 1'b0, 2'd2);
    In2 = 8'h11; #1; check("sl_ready", rdy(), 8'h04);
    step(); check_out("sl1", 8'h11, 1'b1, 1'b0, 2'd2);
    In2 = 8'h12;
    step(); check_out("sl2", 8'h12, 1'b1, 1'b0, 2'd2);
    drive(4'b1010, 8'h00, 8'h51, 8'h00, 8'h53);
    #1; check("wrap_ready", rdy(), 8'h08);
    step(); check_out("wrap3", 8'h53, 1'b1, 1'b0, 2'd3);
    check("wrap_ready1", rdy(), 8'h02);
    step(); check_out("wrap1", 8'h51, 1'b1, 1'b0, 2'd1);

    // Idle counting: no valids
    reset = 1'b1; step(); reset = 1'b0;
    drive(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++) begin
      step();
      check("idle_valid", {7'h0, valid_out}, 8'h00);
    end
`ifdef PHY_TX_SKP_INSERT_EN
    step(); check_out("idle_com", COM, 1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 3; i++) begin
      step(); check_out("idle_skp", SKP, 1'b1, 1'b1, 2'd0);
    end
`else
    for (int i = 0; i < 4; i++) begin
      step(); check("idle_valid", {7'h0, valid_out}, 8'h00);
    end
`endif

    // SKP insertion with all lanes valid, followed by reset in mid ordered set
    reset = 1'b1; step(); reset = 1'b0;
    drive(4'hF, 8'hA0, 8'hA1, 8'hA2, 8'hA3);
    for (int i = 0; i < 16; i++) begin
      step();
      check_out("skp_data", 8'hA0 + 8'(i % 4), 1'b1, 1'b0, 2'(i % 4));
    end
`ifdef PHY_TX_SKP_INSERT_EN
    check("skp_ready", rdy(), 8'h00);
    step(); check_out("skp_com", COM, 1'b1, 1'b1, 2'd3);
    check("skp_ready", rdy(), 8'h00);
    step(); check_out("skp_s1", SKP, 1'b1, 1'b1, 2'd3);
    reset = 1'b1;
    #1; check("mid_ready", rdy(), 8'h00);
    step(); check_out("mid_rst", 8'h00, 1'b0, 1'b0, 2'd0);
    reset = 1'b0;
    #1; check("mid_ready0", rdy(), 8'h01);
    step(); check_out("mid_first", 8'hA0, 1'b1, 1'b0, 2'd0);
    for (int i = 1; i < 16; i++) step();
    check_out("mid_last", 8'hA3, 1'b1, 1'b0, 2'd3);
    step(); check_out("mid_com", COM, 1'b1, 1'b1, 2'd3);
    for (int i = 0; i < 3; i++) step();
    check_out("mid_skp3", SKP, 1'b1, 1'b1, 2'd3);
    step(); check_out("mid_resume", 8'hA0, 1'b1, 1'b0, 2'd0);
`else
    step(); check_out("noskp", 8'hA0, 1'b1, 1'b0, 2'd0);
`endif

    // Mixed valid patterns, checked by the model every cycle
    reset = 1'b1; step(); reset = 1'b0;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 12; i++) begin
        drive(pats[i], 8'(i * 4 + r * 64), 8'(i * 4 + 1 + r * 64),
              8'(i * 4 + 2 + r * 64), 8'(i * 4 + 3 + r * 64));
        step();
      end
    end

    drive(4'h0, 8'h00, 8'h00, 8'h00, 8'h00);
    step(); step();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/phy_tx_lane_sched.md
# phy_tx_lane_sched

Round-robin byte scheduler for the PHY transmit path. Four byte requesters share one byte-wide transmit slot; the block grants one requester per cycle with a ready/valid handshake. It drives a registered byte stream, with valid and a K-symbol flag, into the PHY TX serializer front end. It can optionally insert periodic SKP ordered sets.

## Interface
- `SKP_INTERVAL`, default 16: number of ARB-state cycles between SKP ordered sets; legal range 4..255.
- `COM_SYM`, default 8'hBC: comma K-symbol.
- `SKP_SYM`, default 8'h1C: skip K-symbol.
- `clk`, input, 1: single clock; all state changes on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `In0`..`In3`, input, 8 each: requester bytes.
- `valid0`..`valid3`, input, 1 each: requester byte valid.
- `ready0`..`ready3`, output, 1 each: combinational grant. A transfer on lane i occurs when `valid_i && ready_i` at a rising edge.
- `data_out`, output, 8: registered byte to the PHY TX.
- `valid_out`, output, 1: `data_out` carries a byte (data or K-symbol).
- `k_out`, output, 1: `data_out` is a K-symbol.
- `grant_id`, output, 2: lane index of the byte currently on `data_out`. Holds its value when idle.

## Operation
- State: round-robin pointer `ptr`, 2 bits, and a state machine {ARB, SKP_COM, SKP_1, SKP_2, SKP_3}. SKP states exist only when the macro is defined.
- Arbitration in ARB:
  - Search lanes ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first with valid high wins.
  - Assert exactly that lane's ready; all other readies are 0.
  - If no lane is valid, all readies are 0.
- On a transfer from lane g:
  - `data_out <= In_g`, `valid_out <= 1`, `k_out <= 0`, `grant_id <= g`.
  - `ptr <= g+1` (mod 4; lane 3 wraps to lane 0).
- With no transfer in ARB: `valid_out <= 0`, `k_out <= 0`, `data_out <= 8'h00`. `ptr` and `grant_id` hold.
- A requester may drop valid without a transfer; nothing is latched and nothing is lost from the block's side.
- In SKP states:
  - All readies are 0 and `ptr` is frozen.
  - SKP_COM registers `COM_SYM`; SKP_1, SKP_2 and SKP_3 each register `SKP_SYM`.
  - Each of these cycles sets `valid_out=1` and `k_out=1`. `grant_id` holds.
- Transitions: SKP_COM -> SKP_1 -> SKP_2 -> SKP_3 -> ARB, unconditionally.
- SKP counter:
  - 8-bit `skp_cnt` increments on every ARB cycle, with or without a transfer.
  - In the ARB cycle where `skp_cnt == SKP_INTERVAL-1`, arbitration still completes normally. Then `skp_cnt <= 0` and the next state is SKP_COM.
  - `skp_cnt` holds in SKP states.
- Reset (any state, including mid-SKP):
  - state = ARB, `ptr` = 0, `skp_cnt` = 0.
  - `data_out` = 8'h00, `valid_out` = 0, `k_out` = 0, `grant_id` = 0.
  - During the reset cycle all readies are 0 and no transfer occurs.

## Timing
- Latency is 1 cycle: the byte accepted at edge N appears on `data_out` after edge N. SKP symbols are registered the same way, one cycle after the state.
- Throughput: one byte per cycle while any lane is valid, except for the 4 SKP cycles in every `SKP_INTERVAL`+4 cycles.
- Readies depend combinationally on `valid0`..`valid3`, `ptr` and state only. There is no combinational path from `In*` to any output.
- A lane held continuously valid is served at least once every 4 ARB cycles, so there is no starvation.

## Configuration
- Macro `PHY_TX_SKP_INSERT_EN`.
- Defined:
  - The SKP state machine and `skp_cnt` are built.
  - The block emits COM, SKP, SKP, SKP every `SKP_INTERVAL` ARB cycles, as described above.
- Undefined:
  - The block is always in ARB; `skp_cnt` and the SKP states are absent.
  - `k_out` is tied to 0 and `SKP_INTERVAL`, `COM_SYM` and `SKP_SYM` are unused.
  - Arbitration and latency are unchanged.

## Test plan
- **Reset values:** hold reset 3 cycles with all four valids high -> readies all 0, `data_out`=00, `valid_out`=0, `k_out`=0, `grant_id`=0 throughout.
- **Round-robin:** after reset, all four valid with In0..In3=A0,A1,A2,A3 -> `data_out`=A0,A1,A2,A3,A0,... one cycle after each grant; `grant_id`=0,1,2,3,0.
- **Single lane and wrap:**
  - Only `valid2` high, `In2` incrementing 10,11,12 -> `ready2` high every cycle, output 10,11,12 back-to-back.
  - Then raise `valid1` and `valid3` together -> lane 3 is granted before lane 1.
- **SKP insertion** (macro defined, `SKP_INTERVAL`=16, all lanes valid) -> 16 data bytes, then BC,1C,1C,1C with `k_out`=1 and all readies 0 for 4 cycles, then data resumes at the lane after the last one granted.
- **Idle counting** (macro defined, no valids) -> `valid_out`=0 for 16 cycles, then BC,1C,1C,1C with `valid_out`=1.
- **Reset mid-SKP:** assert reset during SKP_2 -> next cycle outputs are 00/0/0 and state is ARB. After release with all lanes valid, lane 0 is granted first, and the next SKP starts after 16 ARB cycles.
